seq_div_unit: RTL and testbench
===============================

Name: seq_div_unit

Overview:
Multi-cycle signed 32-bit divider that is the divide engine behind the ALU's DIV opcode (5'b01111).
- Captures the Y-register operand (dividend) and the bus operand (divisor) on a start pulse.
- Runs a restoring shift-subtract loop and presents a 64-bit result for the Z register: remainder in the high word (to HI via ZHighOut), quotient in the low word (to LO via ZLowOut).
- The control step that asserts Zin holds until done is seen.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH bits.

Ports:
clock  in  1  system clock, rising-edge.
clear  in  1  synchronous active-high reset.
start  in  1  one-cycle request; operands sampled when start=1 and busy=0.
dividend  in  WIDTH  signed dividend (Y register).
divisor  in  WIDTH  signed divisor (bus).
busy  out  1  high while an operation is in flight.
done  out  1  one-cycle pulse when result becomes valid.
result  out  2*WIDTH  {remainder, quotient}, held until the next accepted start.

Behaviour:
- Reset: clear sampled high at a rising edge forces state=IDLE and busy=0, done=0, result=0, all internal registers 0. Clear mid-operation aborts the operation; no done is issued.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 latches |dividend| and |divisor| as unsigned WIDTH-bit magnitudes, the sign of the dividend, and sign_q = sign(dividend) XOR sign(divisor).
  - Partial remainder := 0; iteration counter := 0; go to CALC.
- CALC: one quotient bit per cycle, MSB first.
  - Shift {rem, quo} left by 1.
  - Trial = rem - divisor_mag, computed at WIDTH+1 bits.
  - If the trial is non-negative, rem := trial and quo[0] := 1; otherwise quo[0] := 0.
  - After WIDTH iterations go to FIX.
- FIX:
  - Quotient negated if sign_q=1.
  - Remainder negated if the dividend was negative (truncate toward zero; remainder takes the dividend's sign).
  - Result register loaded; go to DONE.
- DONE: done=1 for exactly this cycle; then IDLE.
- Latency: start sampled at edge k → done high during the cycle after edge k+WIDTH+1 (34 cycles for WIDTH=32). busy is high from edge k+1 until the edge that enters IDLE.
- Overflow: 0x80000000 / -1 → quotient 0x80000000, remainder 0 (magnitude 2^31 negates to itself); no flag.
- Divide by zero (base behaviour): the algorithm runs unmodified and gives quotient magnitude all-ones, remainder magnitude = |dividend|, then the FIX signs apply. Latency is unchanged.
- start while busy: ignored; no effect on the operation in flight.
- start in the same cycle as clear: clear wins.
- result changes only at the FIX edge or on clear; operands may change freely after acceptance.

Optional Feature:
DIV_ZERO_TRAP_EN
- Defined:
  - Adds output div_zero (1 bit; reset 0; set with result, held until the next accepted start).
  - divisor==0 at acceptance skips CALC: IDLE→FIX→DONE, so done arrives 2 cycles after start.
  - Result is forced to {dividend, 32'hFFFFFFFF}.
- Not defined: the div_zero port is absent; divide by zero follows the base behaviour above.

Test Plan:
1. dividend=0xFFFFFFFB (-5), divisor=25, start → done at cycle 34, result=0xFFFFFFFB_00000000.
2. 100 / 7 → result=0x00000002_0000000E; -100 / 7 → result=0xFFFFFFFE_FFFFFFF2; 100 / -7 → 0x00000002_FFFFFFF2.
3. 0x80000000 / 0xFFFFFFFF → result=0x00000000_80000000, busy low after done.
4. Divide by zero:
   - 37 / 0 without the macro → result=0x00000025_FFFFFFFF after 34 cycles.
   - Same stimulus with DIV_ZERO_TRAP_EN → same result at cycle 2, div_zero=1.
5. Start 100/7; at cycle 10 pulse start with 9/3 → ignored, result 0x00000002_0000000E; at cycle 20 assert clear → busy=0, result=0, no done pulse.
6. Back-to-back: start asserted in the cycle after done → second operation accepted; its done comes 34 cycles later; first result held until the second FIX edge.

Source files
------------

// File: rtl/seq_div_unit.sv
// Multi-cycle signed restoring divider: result = {remainder, quotient}, truncating toward zero.
// Optional macro DIV_ZERO_TRAP_EN adds a div_zero flag and a short-circuit path for a zero divisor.
module seq_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
`ifdef DIV_ZERO_TRAP_EN
  ,
  output logic               div_zero
`endif
);

  // state | meaning
  // IDLE  | waiting for start; result held
  // CALC  | one quotient bit per cycle, MSB first
  // FIX   | apply signs, load result
  // DONE  | done pulse, back to IDLE
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dvs_mag, rem, quo;
  logic             dvd_neg, sign_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             dvs_zero;

  assign dvs_zero = (divisor == '0);

  // quo starts out holding |dividend| and is shifted out as quotient bits shift in
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, dvs_mag};
  assign quo_fix = sign_q  ? -quo : quo;
  assign rem_fix = dvd_neg ? -rem : rem;

`ifdef DIV_ZERO_TRAP_EN
  logic dz_q;
`endif

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_TRAP_EN
          state_nxt = dvs_zero ? FIX : CALC;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= IDLE;
      dvs_mag <= '0;
      rem     <= '0;
      quo     <= '0;
      dvd_neg <= 1'b0;
      sign_q  <= 1'b0;
      cnt     <= '0;
      result  <= '0;
`ifdef DIV_ZERO_TRAP_EN
      dz_q     <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            quo     <= dividend[WIDTH-1] ? -dividend : dividend;
            dvs_mag <= divisor[WIDTH-1]  ? -divisor  : divisor;
            dvd_neg <= dividend[WIDTH-1];
            sign_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rem     <= '0;
            cnt     <= '0;
`ifdef DIV_ZERO_TRAP_EN
            dz_q     <= dvs_zero;
            div_zero <= 1'b0;
`endif
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
`ifdef DIV_ZERO_TRAP_EN
          // on the trap path quo still holds |dividend|, so the signed dividend is rebuilt from it
          if (dz_q) begin
            result   <= {(dvd_neg ? -quo : quo), {WIDTH{1'b1}}};
            div_zero <= 1'b1;
          end else begin
            result <= {rem_fix, quo_fix};
          end
`else
          result <= {rem_fix, quo_fix};
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_unit.sv
// Directed self-checking bench for seq_div_unit: vector table plus multi-cycle corner sequences.
module tb_seq_div_unit;

  logic        clock = 1'b0;
  logic        clear, start;
  logic [31:0] dividend, divisor;
  logic        busy, done;
  logic [63:0] result;
  logic        div_zero;

  int tests = 0;
  int fails = 0;

`ifdef DIV_ZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
  assign div_zero = 1'b0;
`endif

  seq_div_unit #(.WIDTH(32)) dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
`ifdef DIV_ZERO_TRAP_EN
    ,
    .div_zero (div_zero)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives one start pulse; returns just after the accepting edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Counts edges until done is seen at a negedge; returns in the done cycle.
  task automatic wait_done(output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (done) got = 1'b1;
    end
  endtask

  vec_t vecs[10];
  int   lat, exp_lat;
  bit   got;
  logic [63:0] held;
  int   seen_done;

  initial begin
    vecs[0] = '{32'hFFFFFFFB, 32'd25,        64'hFFFFFFFB_00000000};
    vecs[1] = '{32'd100,      32'd7,         64'h00000002_0000000E};
    vecs[2] = '{32'hFFFFFF9C, 32'd7,         64'hFFFFFFFE_FFFFFFF2};
    vecs[3] = '{32'd100,      32'hFFFFFFF9,  64'h00000002_FFFFFFF2};
    vecs[4] = '{32'h80000000, 32'hFFFFFFFF,  64'h00000000_80000000};
    vecs[5] = '{32'd37,       32'd0,         64'h00000025_FFFFFFFF};
    vecs[6] = '{32'hFFFFFFF9, 32'hFFFFFFFE,  64'hFFFFFFFF_00000003};
    vecs[7] = '{32'h7FFFFFFF, 32'd2,         64'h00000001_3FFFFFFF};
    vecs[8] = '{32'd0,        32'd5,         64'h00000000_00000000};
    vecs[9] = '{32'hFFFFFFFF, 32'd0,
                TRAP ? 64'hFFFFFFFF_FFFFFFFF : 64'hFFFFFFFF_00000001};

    clear = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_done", int'(done), 0);
    check64("reset_result", result, 64'h0);
    clear = 1'b0;

    for (int i = 0; i < 10; i++) begin
      exp_lat = (TRAP && vecs[i].b == 32'd0) ? 1 : 33;
      launch(vecs[i].a, vecs[i].b);
      wait_done(lat, got);
      check_int($sformatf("v%0d_done_seen", i), int'(got), 1);
      check_int($sformatf("v%0d_latency", i), lat, exp_lat);
      check64($sformatf("v%0d_result", i), result, vecs[i].exp);
      check_int($sformatf("v%0d_div_zero", i), int'(div_zero),
                int'(TRAP && vecs[i].b == 32'd0));
      @(negedge clock);
      check_int($sformatf("v%0d_done_pulse", i), int'(done), 0);
      check_int($sformatf("v%0d_busy_after", i), int'(busy), 0);
    end

    // start while busy is ignored
    launch(32'd100, 32'd7);
    repeat (10) @(posedge clock);
    @(negedge clock);
    check_int("busy_mid_op", int'(busy), 1);
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(lat, got);
    check_int("intrude_latency", 11 + lat, 33);
    check64("intrude_result", result, 64'h00000002_0000000E);

    // back-to-back: start in the cycle after done; old result held until next FIX
    held = result;
    launch(32'hFFFFFF9C, 32'd7);
    repeat (20) @(posedge clock);
    @(negedge clock);
    check64("b2b_held", result, held);
    wait_done(lat, got);
    check_int("b2b_latency", 20 + lat, 33);
    check64("b2b_result", result, 64'hFFFFFFFE_FFFFFFF2);
    @(negedge clock);

    // clear mid-operation aborts with no done
    launch(32'd100, 32'd7);
    repeat (19) @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock);
    check_int("clear_busy", int'(busy), 0);
    check64("clear_result", result, 64'h0);
    seen_done = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) seen_done++;
    end
    check_int("clear_no_done", seen_done, 0);

    // start together with clear: clear wins
    @(negedge clock);
    clear = 1'b1; start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge clock);
    #1 begin clear = 1'b0; start = 1'b0; end
    @(negedge clock);
    check_int("start_with_clear_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
